// File: rtl/stream_driver.sv
// Burst stream source: emits len beats of seed, seed+1, ... over a valid/ready port.
// Define STREAM_DRIVER_RAND_GAP_EN to insert LFSR-driven idle gaps between beats.
module stream_driver #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic [DATA_W-1:0] seed,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_count,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef STREAM_DRIVER_RAND_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DATA_W-1:0] D_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0] state;
  logic [7:0] beat_len;
  logic [7:0] beat_idx;
  logic       hs;
  logic       last;

  assign hs   = o_valid & o_ready;
  assign last = (beat_idx == beat_len - 8'd1);

`ifdef STREAM_DRIVER_RAND_GAP_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;

  // Fibonacci form of x^8+x^6+x^5+x^4+1
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_ff @(posedge clock) begin
    if (reset)
      lfsr <= 8'hA5;
    else if (hs)
      lfsr <= lfsr_next;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      beat_len <= 8'd0;
      beat_idx <= 8'd0;
      o_valid  <= 1'b0;
      o_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            beat_len <= len;
            beat_idx <= 8'd0;
            o_data   <= seed;
            if (len != 8'd0) begin
              state   <= S_SEND;
              o_valid <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (hs) begin
            if (last) begin
              state   <= S_DONE;
              o_valid <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              beat_idx <= beat_idx + 8'd1;
              o_data   <= o_data + D_ONE;
`ifdef STREAM_DRIVER_RAND_GAP_EN
              if (lfsr_next[0]) begin
                state   <= S_GAP;
                o_valid <= 1'b0;
              end
`endif
            end
          end
        end
`ifdef STREAM_DRIVER_RAND_GAP_EN
        S_GAP: begin
          state   <= S_SEND;
          o_valid <= 1'b1;
        end
`endif
        default: begin
          state   <= S_IDLE;
          o_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sent_count  <= '0;
      stall_count <= '0;
    end else begin
      if (hs && sent_count != '1)
        sent_count <= sent_count + C_ONE;
      if (o_valid && !o_ready && stall_count != '1)
        stall_count <= stall_count + C_ONE;
    end
  end

endmodule

// File: tb/tb_stream_driver.sv
// Directed self-checking bench for stream_driver.
// Tracks gap timing with a reference LFSR when STREAM_DRIVER_RAND_GAP_EN is set.
module tb_stream_driver;

`ifdef STREAM_DRIVER_RAND_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len   = 8'd0;
  logic [7:0]  seed  = 8'd0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [7:0]  o_data;
  logic        busy;
  logic        done;
  logic [15:0] sent_count;
  logic [15:0] stall_count;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_sent  = 0;
  int exp_stall = 0;
  logic [7:0] lfsr_m = 8'hA5;

  stream_driver #(.DATA_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .len(len),
    .seed(seed), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .busy(busy), .done(done),
    .sent_count(sent_count), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
    lfsr_m    = 8'hA5;
    exp_sent  = 0;
    exp_stall = 0;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sent", sent_count, 0);
    chk("rst_stall", stall_count, 0);
  endtask

  // Runs one burst; o_ready is held low for the first n_stall cycles.
  // With chain=1 it returns in the done cycle so the next start lands in DONE.
  task automatic run_burst(input logic [7:0] l, input logic [7:0] s,
                           input int n_stall, input bit chain);
    int  k   = 0;
    int  cyc = 0;
    bit  gap = 1'b0;
    bit  ev;
    logic [7:0] d;
    start = 1'b1;
    len   = l;
    seed  = s;
    step();
    start = 1'b0;
    while (k < int'(l) && cyc < 200) begin
      o_ready = (cyc >= n_stall);
      start   = (cyc == 1);
      if (cyc == 1) seed = 8'h5A;
      ev = !gap;
      d  = s + 8'(k);
      chk("b_valid", o_valid, ev);
      chk("b_busy", busy, 1);
      chk("b_done", done, 0);
      if (ev) chk("b_data", o_data, d);
      gap = 1'b0;
      if (ev && o_ready) begin
        k++;
        exp_sent++;
        lfsr_m = lfsr_adv(lfsr_m);
        gap = GAP_EN && (k < int'(l)) && lfsr_m[0];
      end else if (ev) begin
        exp_stall++;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    if (cyc >= 200) chk("timeout", 0, 1);
    o_ready = 1'b1;
    chk("end_done", done, 1);
    chk("end_valid", o_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_sent", sent_count, exp_sent);
    chk("end_stall", stall_count, exp_stall);
    if (!chain) begin
      step();
      chk("post_done", done, 0);
      chk("post_valid", o_valid, 0);
    end
  endtask

  initial begin
    step();
    do_reset();

    run_burst(8'd4, 8'h10, 0, 1'b0);
    chk("sent4", sent_count, 4);

    run_burst(8'd3, 8'hFE, 0, 1'b0);

    run_burst(8'd2, 8'h33, 5, 1'b0);
    chk("stall5", stall_count, 5);

    run_burst(8'd0, 8'h99, 0, 1'b0);
    chk("len0_sent", sent_count, 9);

    run_burst(8'd2, 8'h80, 0, 1'b1);
    run_burst(8'd3, 8'hC0, 2, 1'b0);

    start = 1'b1;
    len   = 8'd6;
    seed  = 8'h40;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    lfsr_m    = 8'hA5;
    exp_sent  = 0;
    exp_stall = 0;
    chk("mid_valid", o_valid, 0);
    chk("mid_data", o_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_sent", sent_count, 0);
    chk("mid_stall", stall_count, 0);
    run_burst(8'd1, 8'h77, 0, 1'b0);

    run_burst(8'd8, 8'h20, 0, 1'b0);
    chk("sent9", sent_count, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_driver.md
STREAM_DRIVER -- requirements
Module: stream_driver

Interface
REQ-001 Parameter: DATA_W, 8, payload width of o_data and seed.
REQ-002 Parameter: CNT_W, 16, width of sent_count and stall_count.
REQ-003 Port: clock  input  1  single clock; all logic samples on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin a burst; sampled only while busy=0.
REQ-006 Port: len  input  8  burst length in beats, captured with start; 0 is legal.
REQ-007 Port: seed  input  DATA_W  first payload value, captured with start.
REQ-008 Port: o_valid  output  1  beat available to downstream receiver.
REQ-009 Port: o_ready  input  1  downstream accepts beat when high together with o_valid.
REQ-010 Port: o_data  output  DATA_W  beat payload.
REQ-011 Port: busy  output  1  burst in progress.
REQ-012 Port: done  output  1  one-cycle pulse at burst completion.
REQ-013 Port: sent_count  output  CNT_W  total accepted beats since reset.
REQ-014 Port: stall_count  output  CNT_W  total cycles with o_valid=1 and o_ready=0 since reset.

Function
REQ-015 States: IDLE, SEND, GAP, DONE; encoding is implementation-defined.
REQ-016 IDLE: start=1 captures len and seed; goes to SEND if len!=0, else to DONE; o_valid first rises the cycle after start.
REQ-017 SEND: o_valid=1; handshake = o_valid & o_ready; each handshake sends one beat.
REQ-018 Beat k (0-based) carries o_data = (seed + k) mod 2^DATA_W; wraps silently.
REQ-019 With o_valid=1 and no handshake: o_valid stays high; o_data holds stable.
REQ-020 Handshake on final beat (k = len-1): next state DONE; o_valid low the next cycle.
REQ-021 DONE: lasts exactly one cycle; done=1, busy=0, o_valid=0; then IDLE.
REQ-022 busy=1 in SEND and GAP, 0 in IDLE and DONE.
REQ-023 start is accepted in IDLE and DONE (busy=0), ignored in SEND/GAP; start in DONE begins a new burst with the same timing as from IDLE.
REQ-024 sent_count increments on each handshake; stall_count increments each cycle o_valid=1 and o_ready=0; both saturate at all-ones.
REQ-025 All outputs are registered; no combinational path from o_ready or start to o_valid or o_data.

Reset
REQ-026 Reset=1 at a clock edge forces IDLE; o_valid=0, o_data=0, busy=0, done=0, sent_count=0, stall_count=0 after that edge.
REQ-027 Reset mid-burst abandons the burst with no done pulse; a start in the first cycle after reset deasserts is accepted.

Configuration
REQ-028 Macro STREAM_DRIVER_RAND_GAP_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1) resets to 0xA5 and advances once per handshake.
REQ-029 With macro: after a non-final handshake, if the advanced LFSR bit0=1, the block spends one GAP cycle (o_valid=0, busy=1) before returning to SEND.
REQ-030 Without macro: no LFSR and no GAP state; beats are back-to-back while o_ready=1.

Verification
REQ-031 Reset, start with len=4, seed=0x10, o_ready=1 (macro off) -> o_valid high 4 consecutive cycles with data 0x10,0x11,0x12,0x13, then done pulse, sent_count=4.
REQ-032 len=3, seed=0xFE -> data 0xFE,0xFF,0x00 (wrap), then done.
REQ-033 len=2, o_ready low 5 cycles then high -> o_data held at seed for 5 cycles, stall_count=5, both beats delivered.
REQ-034 len=0 -> no o_valid; done pulses the cycle after start; sent_count unchanged.
REQ-035 Reset asserted after 2 of 6 beats -> all outputs zero after the reset edge, no done pulse; a new start with len=1 completes normally.
REQ-036 Macro on, len=8, o_ready=1 -> each idle gap occurs exactly when the LFSR model gives bit0=1; data sequence identical to macro off.
